multi_push_fifo: RTL and testbench

//  Circular FIFO that accepts 0..NUM_LANES entries per cycle and returns one entry per cycle.
//  It sits upstream of single-issue consumers and takes packed multi-lane producer output.

---
 rtl/multi_push_fifo_pkg.sv | 9 +
 rtl/rotating_xbar.sv | 23 ++
 rtl/multi_push_fifo.sv | 103 ++++++++++
 tb/tb_multi_push_fifo.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/multi_push_fifo_pkg.sv
// Shared helpers for the multi-push FIFO and its lane-alignment crossbar.
package multi_push_fifo_pkg;

    // Width of an index into v items, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 2) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/rotating_xbar.sv
// Rotating crossbar: output i takes input (i + select) mod NUM_DATA.
module rotating_xbar
    import multi_push_fifo_pkg::*;
#(
    parameter int unsigned NUM_DATA   = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [NUM_DATA-1:0][DATA_WIDTH-1:0]    data_i,
    input  logic [clog2_min1(NUM_DATA)-1:0]        select_i,
    output logic [NUM_DATA-1:0][DATA_WIDTH-1:0]    data_o
);

    localparam int unsigned SEL_W = clog2_min1(NUM_DATA);

    // NUM_DATA is a power of two, so the SEL_W-bit add wraps modulo NUM_DATA.
    always_comb begin
        data_o = '0;
        for (int i = 0; i < NUM_DATA; i++) begin
            data_o[i] = data_i[SEL_W'(i) + select_i];
        end
    end

endmodule

// File: rtl/multi_push_fifo.sv
// Circular FIFO taking 0..NUM_LANES entries per cycle and returning one per cycle,
// stored as NUM_LANES banks with lanes rotated onto banks by the write pointer.
module multi_push_fifo
    import multi_push_fifo_pkg::*;
#(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                                    clk_i,
    input  logic                                    arst_ni,
    input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]    data_in_i,
    input  logic [$clog2(NUM_LANES+1)-1:0]          push_count_i,
    output logic                                    push_ready_o,
    output logic [DATA_WIDTH-1:0]                   data_out_o,
    output logic                                    data_out_valid_o,
    input  logic                                    data_out_ready_i,
    output logic [$clog2(DEPTH):0]                  count_o
);

    localparam int unsigned ROWS   = DEPTH / NUM_LANES;
    localparam int unsigned PTR_W  = $clog2(DEPTH) + 1;
    localparam int unsigned IDX_W  = PTR_W - 1;
    localparam int unsigned LANE_W = clog2_min1(NUM_LANES);
    localparam int unsigned ROW_W  = clog2_min1(ROWS);
    localparam int unsigned CNT_W  = $clog2(NUM_LANES + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] free_cnt;
    logic             push_fire;
    logic             pop_fire;

    logic [LANE_W-1:0]                        start_sel;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0]     bank_wdata;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0]     bank_rdata;
    logic [LANE_W-1:0]                        wr_lane;
    logic [ROW_W-1:0]                         wr_row;

    always_comb begin
        count            = wr_ptr_q - rd_ptr_q;
        free_cnt         = PTR_W'(DEPTH) - count;
        // Ready uses pre-pop free space; a same-cycle pop gives no credit.
        push_ready_o     = free_cnt >= PTR_W'(push_count_i);
        data_out_valid_o = count != '0;
        push_fire        = push_ready_o && (push_count_i != '0);
        pop_fire         = data_out_valid_o && data_out_ready_i;
        wr_ptr_d         = push_fire ? wr_ptr_q + PTR_W'(push_count_i) : wr_ptr_q;
        rd_ptr_d         = pop_fire ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_o          = count;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign wr_lane   = wr_ptr_q[LANE_W-1:0];
    assign wr_row    = wr_ptr_q[IDX_W-1:LANE_W];
    // (NUM_LANES - wr_lane) mod NUM_LANES; the modulo is the natural LANE_W wrap.
    assign start_sel = LANE_W'(0) - wr_lane;

    rotating_xbar #(
        .NUM_DATA   (NUM_LANES),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_xbar (
        .data_i   (data_in_i),
        .select_i (start_sel),
        .data_o   (bank_wdata)
    );

    for (genvar b = 0; b < NUM_LANES; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem_q [ROWS];
        logic [LANE_W-1:0]     lane_off;
        logic [ROW_W-1:0]      row;
        logic                  we;

        assign lane_off = LANE_W'(b) - wr_lane;
        // Banks below the write lane belong to the next row of this burst.
        assign row      = wr_row + ROW_W'(LANE_W'(b) < wr_lane);
        assign we       = push_fire && (CNT_W'(lane_off) < push_count_i);

        always_ff @(posedge clk_i) begin
            if (we) begin
                mem_q[row] <= bank_wdata[b];
            end
        end

        assign bank_rdata[b] = mem_q[rd_ptr_q[IDX_W-1:LANE_W]];
    end

    assign data_out_o = bank_rdata[rd_ptr_q[LANE_W-1:0]];

    push_count_legal: assert property (@(posedge clk_i) disable iff (!arst_ni)
        push_count_i <= CNT_W'(NUM_LANES));

endmodule

// File: tb/tb_multi_push_fifo.sv
// Directed bench for multi_push_fifo: reset, rotation, full, concurrent, wrap, mid-run reset.
module tb_multi_push_fifo;

    logic             clk_i;
    logic             arst_ni;
    logic [3:0][7:0]  data_in_i;
    logic [2:0]       push_count_i;
    logic             push_ready_o;
    logic [7:0]       data_out_o;
    logic             data_out_valid_o;
    logic             data_out_ready_i;
    logic [4:0]       count_o;

    int checks   = 0;
    int failures = 0;

    multi_push_fifo #(
        .NUM_LANES  (4),
        .DATA_WIDTH (8),
        .DEPTH      (16)
    ) dut (
        .clk_i            (clk_i),
        .arst_ni          (arst_ni),
        .data_in_i        (data_in_i),
        .push_count_i     (push_count_i),
        .push_ready_o     (push_ready_o),
        .data_out_o       (data_out_o),
        .data_out_valid_o (data_out_valid_o),
        .data_out_ready_i (data_out_ready_i),
        .count_o          (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, 32'(data_out_valid_o), 1);
        chk(tag, 32'(data_out_o), 32'(exp));
        data_out_ready_i = 1'b1;
        step();
        data_out_ready_i = 1'b0;
    endtask

    task automatic push(input logic [2:0] n, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
        data_in_i    = {d3, d2, d1, d0};
        push_count_i = n;
        step();
        push_count_i = 3'd0;
    endtask

    logic [7:0] q[$];
    int         pushed;
    int         cyc;
    int         pc;
    logic       rdy;
    logic       exp_ready;

    initial begin
        arst_ni          = 1'b1;
        data_in_i        = '0;
        push_count_i     = 3'd0;
        data_out_ready_i = 1'b0;

        // 1. Asynchronous reset mid-cycle
        #3 arst_ni = 1'b0;
        push_count_i = 3'd4;
        #1;
        chk("rst_count", 32'(count_o), 0);
        chk("rst_valid", 32'(data_out_valid_o), 0);
        chk("rst_ready4", 32'(push_ready_o), 1);
        push_count_i = 3'd0;
        @(negedge clk_i);
        arst_ni = 1'b1;
        step();

        // 2. Rotation across banks
        push(3'd3, 8'h0A, 8'h0B, 8'h0C, 8'h00);
        push(3'd4, 8'h0D, 8'h0E, 8'h0F, 8'h10);
        chk("rot_count", 32'(count_o), 7);
        pop_chk("rot_pop0", 8'h0A);
        pop_chk("rot_pop1", 8'h0B);
        pop_chk("rot_pop2", 8'h0C);
        pop_chk("rot_pop3", 8'h0D);
        pop_chk("rot_pop4", 8'h0E);
        pop_chk("rot_pop5", 8'h0F);
        pop_chk("rot_pop6", 8'h10);
        chk("rot_empty", 32'(data_out_valid_o), 0);

        // 3. Full
        for (int i = 0; i < 4; i++) begin
            push(3'd4, 8'(8'h20 + 4*i), 8'(8'h21 + 4*i), 8'(8'h22 + 4*i), 8'(8'h23 + 4*i));
        end
        chk("full_count", 32'(count_o), 16);
        push_count_i = 3'd1;
        data_in_i    = {8'h99, 8'h99, 8'h99, 8'h99};
        #1;
        chk("full_ready1", 32'(push_ready_o), 0);
        step();
        chk("full_no_push", 32'(count_o), 16);
        push_count_i = 3'd0;
        #1;
        chk("full_ready0", 32'(push_ready_o), 1);
        pop_chk("full_pop", 8'h20);
        chk("full_after_pop", 32'(count_o), 15);
        push_count_i = 3'd1;
        #1;
        chk("full_ready_after_pop", 32'(push_ready_o), 1);
        push_count_i = 3'd0;
        for (int i = 1; i < 16; i++) begin
            pop_chk("full_drain", 8'(8'h20 + i));
        end
        chk("full_drained", 32'(count_o), 0);

        // 4. Concurrent push and pop
        push(3'd4, 8'h30, 8'h31, 8'h32, 8'h33);
        push(3'd1, 8'h34, 8'h00, 8'h00, 8'h00);
        chk("conc_count5", 32'(count_o), 5);
        data_in_i        = {8'h00, 8'h00, 8'h36, 8'h35};
        push_count_i     = 3'd2;
        data_out_ready_i = 1'b1;
        #1;
        chk("conc_oldest", 32'(data_out_o), 32'h30);
        step();
        push_count_i     = 3'd0;
        data_out_ready_i = 1'b0;
        chk("conc_count6", 32'(count_o), 6);
        for (int i = 1; i < 7; i++) begin
            pop_chk("conc_drain", 8'(8'h30 + i));
        end

        // 5. Streaming wrap with scoreboard
        pushed = 0;
        cyc    = 0;
        while ((pushed < 40 || q.size() != 0) && cyc < 2000) begin
            pc = $urandom_range(0, 4);
            if (pushed + pc > 40) pc = 40 - pushed;
            rdy = 1'($urandom_range(0, 1));
            for (int j = 0; j < 4; j++) data_in_i[j] = 8'(8'h80 + pushed + j);
            push_count_i     = 3'(pc);
            data_out_ready_i = rdy;
            #3;
            exp_ready = (16 - q.size()) >= pc;
            chk("wrap_count", 32'(count_o), 32'(q.size()));
            chk("wrap_le_depth", 32'(count_o <= 5'd16), 1);
            chk("wrap_ready", 32'(push_ready_o), 32'(exp_ready));
            chk("wrap_valid", 32'(data_out_valid_o), 32'(q.size() != 0));
            if (rdy && q.size() != 0) begin
                chk("wrap_data", 32'(data_out_o), 32'(q[0]));
                void'(q.pop_front());
            end
            if (exp_ready && pc != 0) begin
                for (int j = 0; j < pc; j++) q.push_back(8'(8'h80 + pushed + j));
                pushed += pc;
            end
            step();
            cyc++;
        end
        chk("wrap_complete", 32'(pushed == 40 && q.size() == 0), 1);
        push_count_i     = 3'd0;
        data_out_ready_i = 1'b0;
        #1;
        chk("wrap_end_count", 32'(count_o), 0);

        // 6. Reset in the middle of operation
        push(3'd4, 8'h60, 8'h61, 8'h62, 8'h63);
        push(3'd4, 8'h64, 8'h65, 8'h66, 8'h67);
        push(3'd1, 8'h68, 8'h00, 8'h00, 8'h00);
        chk("mid_count9", 32'(count_o), 9);
        #2 arst_ni = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count_o), 0);
        chk("mid_rst_valid", 32'(data_out_valid_o), 0);
        #1 arst_ni = 1'b1;
        step();
        chk("mid_post_count", 32'(count_o), 0);
        push(3'd1, 8'h55, 8'h00, 8'h00, 8'h00);
        chk("mid_push_count", 32'(count_o), 1);
        pop_chk("mid_pop", 8'h55);
        chk("mid_final_count", 32'(count_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
